// File: rtl/mult_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: mode encodings,
// FSM state type and Booth digit type.
package mult_pkg;

    localparam logic [1:0] MODE_MUL   = 2'b00;
    localparam logic [1:0] MODE_SMULH = 2'b01;
    localparam logic [1:0] MODE_UMULH = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Booth digit in sign/magnitude form: value = (neg ? -1 : 1) * (zero ? 0 : (two ? 2 : 1))
    typedef struct packed {
        logic neg;
        logic two;
        logic zero;
    } booth_digit_t;

    // High-half modes select acc[2W-1:W]; MUL and the spare encoding select the low half
    function automatic logic mode_is_high(input logic [1:0] mode);
        return (mode == MODE_SMULH) || (mode == MODE_UMULH);
    endfunction

endpackage

// File: rtl/booth_encoder.sv
// Combinational radix-4 Booth recoder: overlapping 3-bit window -> {neg, two, zero}.
module booth_encoder
    import mult_pkg::*;
(
    input  logic [2:0]   i_bits,
    output booth_digit_t o_digit_c
);

    // 100 -> -2, 101/110 -> -1; 111 is zero and stays non-negative
    assign o_digit_c.neg  = i_bits[2] & ~(i_bits[1] & i_bits[0]);
    assign o_digit_c.two  = (i_bits == 3'b011) || (i_bits == 3'b100);
    assign o_digit_c.zero = (i_bits == 3'b000) || (i_bits == 3'b111);

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-4 Booth multiplier, one digit per cycle (IDLE -> RUN -> DONE).
// Define MULT_EARLY_TERM_EN to leave RUN once the remaining multiplier bits are all sign.
module booth_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             start,
    input  logic [1:0]       mult_mode,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int unsigned XW = WIDTH + 2;
    localparam int unsigned RW = WIDTH + 3;
    localparam int unsigned AW = 2 * WIDTH + 4;
    localparam int unsigned N  = (WIDTH + 2) / 2;
    localparam int unsigned CW = $clog2(N + 1);

    generate
        if (((WIDTH % 2) != 0) || (WIDTH < 8)) begin : g_bad_width
            $fatal(1, "booth_multiplier: WIDTH must be even and >= 8");
        end
    endgenerate

    state_t          r_state;
    state_t          w_state_next;
    logic            w_load;
    logic            w_step;
    logic            w_finish;
    logic            w_term;

    logic [1:0]      r_mode;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   r_mcand;
    logic [RW-1:0]   r_rreg;
    logic [CW-1:0]   r_count;
    logic [WIDTH-1:0] r_result;
    logic            r_busy;
    logic            r_done;

    logic [XW-1:0]   w_ext_a;
    logic [XW-1:0]   w_ext_b;
    logic [RW-1:0]   w_r_shift;
    logic [AW-1:0]   w_pp;
    booth_digit_t    w_digit;

    booth_encoder u_booth_encoder (
        .i_bits    (r_rreg[2:0]),
        .o_digit_c (w_digit)
    );

    // Unsigned high mode zero-extends; every other mode sign-extends
    assign w_ext_a = (mult_mode == MODE_UMULH) ? {2'b00, multiplicand}
                                               : {{2{multiplicand[WIDTH-1]}}, multiplicand};
    assign w_ext_b = (mult_mode == MODE_UMULH) ? {2'b00, multiplier}
                                               : {{2{multiplier[WIDTH-1]}}, multiplier};

    assign w_r_shift = {{2{r_rreg[RW-1]}}, r_rreg[RW-1:2]};
    assign w_pp      = w_digit.zero ? '0
                     : (w_digit.two ? {r_mcand[AW-2:0], 1'b0} : r_mcand);

`ifdef MULT_EARLY_TERM_EN
    // Remaining window all-sign means every further digit would be zero
    assign w_term = (r_count == CW'(N - 1)) || (w_r_shift == '0) || (w_r_shift == '1);
`else
    assign w_term = (r_count == CW'(N - 1));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Stall freezes the FSM, so strobes are only raised when not stalled
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        if (!stall) begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_load       = 1'b1;
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_step = 1'b1;
                    if (w_term) begin
                        w_state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_finish     = 1'b1;
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode   <= MODE_MUL;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_rreg   <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (!stall) begin
            r_busy <= (w_state_next != ST_IDLE);
            r_done <= w_finish;
            if (w_load) begin
                r_mode  <= mult_mode;
                r_acc   <= '0;
                r_mcand <= AW'($signed(w_ext_a));
                r_rreg  <= {w_ext_b, 1'b0};
                r_count <= '0;
            end
            if (w_step) begin
                r_acc   <= w_digit.neg ? (r_acc - w_pp) : (r_acc + w_pp);
                r_mcand <= {r_mcand[AW-3:0], 2'b00};
                r_rreg  <= w_r_shift;
                r_count <= r_count + CW'(1);
            end
            if (w_finish) begin
                r_result <= mode_is_high(r_mode) ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
            end
        end
    end

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: doc/booth_multiplier.md
BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width; even and >= 8.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port stall  input  1  freezes all internal state while high.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port mult_mode  input  2  00 MUL (low half), 01 SMULH (signed high half), 10 UMULH (unsigned high half), 11 treated as 00.
REQ-007 SHALL have port multiplicand  input  WIDTH  operand A; sampled with start.
REQ-008 SHALL have port multiplier  input  WIDTH  operand B; sampled with start.
REQ-009 SHALL have port result  output  WIDTH  selected product half; registered.
REQ-010 SHALL have port busy  output  1  high in RUN and DONE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when result updates.

Function
REQ-012 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE; no other states.
REQ-013 In IDLE with start=1 and stall=0: capture operands, sign-extend (modes 00/01) or zero-extend (10) both to WIDTH+2 bits, clear the 2*WIDTH+4 accumulator and the iteration counter, and enter RUN.
REQ-014 RUN SHALL use radix-4 Booth: R = {ext_multiplier, 1'b0}; digit from R[2:0] in {-2,-1,0,+1,+2}; acc += digit * M; M <<= 2; R >>>= 2; one digit per cycle.
REQ-015 RUN SHALL last N = (WIDTH+2)/2 unstalled cycles (33 for WIDTH=64) and then enter DONE.
REQ-016 In DONE: result <= acc[WIDTH-1:0] for mode 00/11, acc[2*WIDTH-1:WIDTH] for 01/10; done=1 for exactly one cycle; next state IDLE.
REQ-017 Latency: done SHALL be high in the cycle N+1 edges after the edge that sampled start, plus one cycle per stalled cycle.
REQ-018 stall=1 SHALL hold state, counter, accumulator, result and done. A done pulse SHALL be extended while stalled.
REQ-019 start outside IDLE SHALL be ignored; operand changes after capture SHALL have no effect.
REQ-020 result SHALL hold its value from DONE until the next DONE.
REQ-021 start and stall both high in IDLE: the request SHALL NOT be accepted.
REQ-022 Operand extremes (most-negative x most-negative, all-ones unsigned) SHALL produce exact products; no overflow flag.

Reset
REQ-023 reset_n low SHALL asynchronously force IDLE, result=0, done=0, busy=0, and clear the accumulator and counter, including mid-RUN; the aborted operation produces no done.
REQ-024 Reset release SHALL be synchronous to clk; the first start SHALL be accepted on the first edge after release.

Configuration
REQ-025 Macro MULT_EARLY_TERM_EN defined: after each RUN cycle, if post-shift R is all-zeros or all-ones, the FSM SHALL enter DONE next; otherwise it SHALL run N cycles.
REQ-026 Without MULT_EARLY_TERM_EN: latency SHALL be fixed at N+1, with no termination comparator synthesised.
REQ-027 Results SHALL be bit-identical with and without the macro.

Structure
REQ-028 A shared package (mult_pkg) SHALL hold the mult_mode encoding constants, the FSM state typedef, and the Booth digit typedef.
REQ-029 A sub-module booth_encoder SHALL be instantiated: combinational, R[2:0] -> {neg, two, zero}.
REQ-030 WIDTH SHALL be checked at elaboration; odd or < 8 is a fatal error.

Verification
REQ-031 mode 00, A=-78, B=99, WIDTH=64, no macro -> result=64'hFFFF_FFFF_FFFF_E1D6, done exactly 34 edges after start.
REQ-032 mode 01, A=-78, B=99 -> result=64'hFFFF_FFFF_FFFF_FFFF; mode 10, A=B=all-ones -> result=64'hFFFF_FFFF_FFFF_FFFE.
REQ-033 start, then stall high for 5 cycles mid-RUN -> done at edge 39, result unchanged vs REQ-031, no state advance while stalled.
REQ-034 reset_n low at edge 10 of RUN -> immediate IDLE, result=0, no done; a new start accepted on the first edge after release completes correctly.
REQ-035 MULT_EARLY_TERM_EN, mode 10, A=3, B=5 -> result high half 0 (low product 15 visible in mode 00), done 3 edges after start.
REQ-036 Random signed/unsigned operands, WIDTH in {8,16,64}, both macro settings -> results match the reference model; start pulses while busy are ignored.
